// File: rtl/fft_r2_sequencer_pkg.sv
// Shared types and address helpers for the radix-2 FFT sequencer.
// The helpers are plain arithmetic so any FFT model can reuse them.
package fft_pkg;

   localparam int unsigned ADDR_W_MAX = 12;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fft_seq_state_e;

   // Sized for the largest legal transform; callers cast down to their own width.
   typedef logic [ADDR_W_MAX-1:0] addr_t;

   function automatic addr_t bfly_addr(input int unsigned b, input int unsigned stage,
                                       input logic bottom);
      int unsigned span;
      int unsigned a;
      span = 32'd1 << stage;
      a    = ((b >> stage) << (stage + 32'd1)) | (b & (span - 32'd1));
      if (bottom) a = a | span;
      return addr_t'(a);
   endfunction

   function automatic addr_t tw_index(input int unsigned b, input int unsigned stage,
                                      input int unsigned log2_n);
      int unsigned span;
      span = 32'd1 << stage;
      return addr_t'((b & (span - 32'd1)) << (log2_n - 32'd1 - stage));
   endfunction

endpackage

// File: rtl/fft_r2_sequencer_if.sv
// Control/address bundle between the FFT sequencer (master) and its surroundings (slave).
// FFT_SEQ_ABORT_EN adds the abort input.
interface fft_r2_sequencer_if #(parameter int LOG2_N = 4);

   logic              start;
`ifdef FFT_SEQ_ABORT_EN
   logic              abort;
`endif
   logic              busy;
   logic              done;
   logic [LOG2_N-1:0] stage;
   logic              rd_en;
   logic [LOG2_N-1:0] rd_addr0;
   logic [LOG2_N-1:0] rd_addr1;
   logic [LOG2_N-2:0] tw_idx;
   logic              bfly_en;
   logic              wr_en;
   logic [LOG2_N-1:0] wr_addr0;
   logic [LOG2_N-1:0] wr_addr1;

   modport master (
      input  start,
`ifdef FFT_SEQ_ABORT_EN
      input  abort,
`endif
      output busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_idx,
             bfly_en, wr_en, wr_addr0, wr_addr1
   );

   modport slave (
      output start,
`ifdef FFT_SEQ_ABORT_EN
      output abort,
`endif
      input  busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_idx,
             bfly_en, wr_en, wr_addr0, wr_addr1
   );

endinterface

// File: rtl/fft_r2_sequencer_addr_delay.sv
// Valid+payload shift register of DEPTH stages with synchronous clear.
module fft_addr_delay #(
   parameter int DEPTH = 1,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [DEPTH-1:0]         valid_q, valid_d;
   logic [DEPTH-1:0][W-1:0]  data_q, data_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      valid_d    = '0;
      data_d     = '0;
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i-1];
         data_d[i]  = data_q[i-1];
      end
      if (clr) begin
         valid_d = '0;
         data_d  = '0;
      end
   end

   // NOTE: the payload is reset along with the valid bits so idle outputs read as zero, not X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/fft_r2_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT with one pipelined butterfly.
// Optional macro FFT_SEQ_ABORT_EN adds an abort input that squashes the transform.
module fft_r2_sequencer
   import fft_pkg::*;
#(
   parameter int LOG2_N   = 4,
   parameter int RD_LAT   = 1,
   parameter int BFLY_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   fft_r2_sequencer_if.master  bus
);

   localparam int L   = RD_LAT + BFLY_LAT;
   localparam int BW  = LOG2_N - 1;
   localparam int DW  = $clog2(L);
   localparam int AW2 = 2 * LOG2_N;

   fft_seq_state_e    state_q, state_d;
   logic [LOG2_N-1:0] stage_q, stage_d;
   logic [BW-1:0]     b_q, b_d;
   logic [DW-1:0]     drain_q, drain_d;

   logic              abort_req;
   logic              start_ok;
   logic              flush;
   logic              rd_en;
   logic [LOG2_N-1:0] rd_addr0, rd_addr1;
   logic [BW-1:0]     tw_idx;
   logic              bfly_v;
   logic [0:0]        bfly_tag;
   logic              wr_v;
   logic [AW2-1:0]    wr_data;

`ifdef FFT_SEQ_ABORT_EN
   assign abort_req = bus.abort;
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      b_d      = b_q;
      drain_d  = drain_q;
      flush    = 1'b0;
      // Abort outranks start; DONE accepts a start so transforms can run back to back.
      start_ok = bus.start & ~abort_req;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = start_ok ? RUN : IDLE;
            stage_d = '0;
            b_d     = '0;
            drain_d = '0;
         end
         RUN: begin
            if (abort_req) begin
               state_d = IDLE;
               stage_d = '0;
               b_d     = '0;
               flush   = 1'b1;
            end else if (b_q == '1) begin
               state_d = DRAIN;
               b_d     = '0;
               drain_d = '0;
            end else begin
               b_d = b_q + 1'b1;
            end
         end
         DRAIN: begin
            if (abort_req) begin
               state_d = IDLE;
               stage_d = '0;
               drain_d = '0;
               flush   = 1'b1;
            end else if (drain_q == DW'(L - 1)) begin
               drain_d = '0;
               if (stage_q == LOG2_N'(LOG2_N - 1)) begin
                  state_d = DONE;
                  stage_d = '0;
               end else begin
                  state_d = RUN;
                  stage_d = stage_q + 1'b1;
               end
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         stage_q <= '0;
         b_q     <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         b_q     <= b_d;
         drain_q <= drain_d;
      end
   end

   // Addresses are forced to zero outside RUN so the delay lines carry clean payloads.
   always_comb begin
      rd_en    = (state_q == RUN);
      rd_addr0 = '0;
      rd_addr1 = '0;
      tw_idx   = '0;
      if (rd_en) begin
         rd_addr0 = LOG2_N'(bfly_addr(32'(b_q), 32'(stage_q), 1'b0));
         rd_addr1 = LOG2_N'(bfly_addr(32'(b_q), 32'(stage_q), 1'b1));
         tw_idx   = BW'(tw_index(32'(b_q), 32'(stage_q), LOG2_N));
      end
   end

   fft_addr_delay #(.DEPTH(L), .W(AW2)) u_wr_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (flush),
      .in_valid  (rd_en),
      .in_data   ({rd_addr0, rd_addr1}),
      .out_valid (wr_v),
      .out_data  (wr_data)
   );

   // Payload mirrors the strobe; both must agree for the butterfly to fire.
   fft_addr_delay #(.DEPTH(RD_LAT), .W(1)) u_bfly_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (flush),
      .in_valid  (rd_en),
      .in_data   (rd_en),
      .out_valid (bfly_v),
      .out_data  (bfly_tag)
   );

   assign bus.busy     = (state_q == RUN) || (state_q == DRAIN);
   assign bus.done     = (state_q == DONE);
   assign bus.stage    = stage_q;
   assign bus.rd_en    = rd_en;
   assign bus.rd_addr0 = rd_addr0;
   assign bus.rd_addr1 = rd_addr1;
   assign bus.tw_idx   = tw_idx;
   assign bus.bfly_en  = bfly_v & bfly_tag[0];
   assign bus.wr_en    = wr_v;
   assign bus.wr_addr0 = wr_data[AW2-1:LOG2_N];
   assign bus.wr_addr1 = wr_data[LOG2_N-1:0];

endmodule

// File: tb/tb_fft_r2_sequencer.sv
// Self-checking bench for fft_r2_sequencer (LOG2_N=3, L=2) against a per-cycle schedule model.
// Abort scenarios are exercised when FFT_SEQ_ABORT_EN is defined.
module tb_fft_r2_sequencer;

   localparam int LOG2_N   = 3;
   localparam int RD_LAT   = 1;
   localparam int BFLY_LAT = 1;
   localparam int L        = RD_LAT + BFLY_LAT;
   localparam int N        = 1 << LOG2_N;
   localparam int HALF     = N / 2;
   localparam int P        = HALF + L;
   localparam int RUN_LEN  = 1 + LOG2_N * P;
   localparam int MAXC     = 1024;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_r2_sequencer_if #(.LOG2_N(LOG2_N)) bus ();

   fft_r2_sequencer #(.LOG2_N(LOG2_N), .RD_LAT(RD_LAT), .BFLY_LAT(BFLY_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit rd, bfly, wr, busy, done;
      int a0, a1, tw, w0, w1, stage;
   } exp_t;

   exp_t plan [MAXC];
   int   cyc;
   int   total;
   int   bad;
   int   rd_cnt;
   int   wr_cnt;
   int   s0;
   int   off;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, expv);
      end
   endtask

   function automatic void clear_from(input int c);
      for (int i = c; i < MAXC; i++) plan[i] = '{default: 0};
   endfunction

   // Expected schedule from the butterfly grouping: stage st has groups of 2*span
   // samples, each pairing j with j+span, twiddle step N/(2*span).
   function automatic void plan_run(input int s);
      int span;
      int base;
      int k;
      int rc;
      int a0;
      for (int st = 0; st < LOG2_N; st++) begin
         span = 1 << st;
         base = s + 1 + st * P;
         k    = 0;
         for (int c = base; c < base + P; c++) begin
            plan[c].busy  = 1'b1;
            plan[c].stage = st;
         end
         for (int g = 0; g < N / (2 * span); g++) begin
            for (int j = 0; j < span; j++) begin
               a0 = g * 2 * span + j;
               rc = base + k;
               plan[rc].rd = 1'b1;
               plan[rc].a0 = a0;
               plan[rc].a1 = a0 + span;
               plan[rc].tw = j * (N / (2 * span));
               plan[rc + RD_LAT].bfly = 1'b1;
               plan[rc + L].wr = 1'b1;
               plan[rc + L].w0 = a0;
               plan[rc + L].w1 = a0 + span;
               k++;
            end
         end
      end
      plan[s + RUN_LEN].done = 1'b1;
   endfunction

   task automatic check_cycle();
      chk("busy",     32'(bus.busy),     32'(plan[cyc].busy));
      chk("done",     32'(bus.done),     32'(plan[cyc].done));
      chk("stage",    32'(bus.stage),    plan[cyc].stage);
      chk("rd_en",    32'(bus.rd_en),    32'(plan[cyc].rd));
      chk("rd_addr0", 32'(bus.rd_addr0), plan[cyc].a0);
      chk("rd_addr1", 32'(bus.rd_addr1), plan[cyc].a1);
      chk("tw_idx",   32'(bus.tw_idx),   plan[cyc].tw);
      chk("bfly_en",  32'(bus.bfly_en),  32'(plan[cyc].bfly));
      chk("wr_en",    32'(bus.wr_en),    32'(plan[cyc].wr));
      chk("wr_addr0", 32'(bus.wr_addr0), plan[cyc].w0);
      chk("wr_addr1", 32'(bus.wr_addr1), plan[cyc].w1);
   endtask

   // One clock cycle: check outputs, drive start/abort, update the model, advance.
   task automatic tick(input bit s, input bit a);
      @(negedge clk);
      check_cycle();
      if (bus.rd_en === 1'b1) rd_cnt++;
      if (bus.wr_en === 1'b1) wr_cnt++;
      bus.start = s;
`ifdef FFT_SEQ_ABORT_EN
      bus.abort = a;
`endif
      if (a) begin
         if (plan[cyc].busy) clear_from(cyc + 1);
      end else if (s && !plan[cyc].busy) begin
         plan_run(cyc);
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic reset_mid();
      @(negedge clk);
      rst_n     = 1'b0;
      bus.start = 1'b0;
      clear_from(cyc);
      #1;
      check_cycle();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_cycle();
      rst_n = 1'b1;
      @(posedge clk);
      cyc++;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      cyc       = 0;
      rd_cnt    = 0;
      wr_cnt    = 0;
      bus.start = 1'b0;
`ifdef FFT_SEQ_ABORT_EN
      bus.abort = 1'b0;
`endif
      clear_from(0);
      #1;
      check_cycle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single transform after a random idle gap; count strobes.
      repeat ($urandom_range(0, 3)) tick(1'b0, 1'b0);
      rd_cnt = 0;
      wr_cnt = 0;
      tick(1'b1, 1'b0);
      repeat (RUN_LEN + 2) tick(1'b0, 1'b0);
      chk("rd_count", rd_cnt, LOG2_N * HALF);
      chk("wr_count", wr_cnt, LOG2_N * HALF);

      // Starts while busy are ignored; a start in the done cycle is honoured.
      tick(1'b1, 1'b0);
      for (int i = 1; i <= RUN_LEN; i++)
         tick((i == 5) || (i == RUN_LEN) || ((i < RUN_LEN) && ($urandom_range(0, 3) == 0)), 1'b0);
      repeat (RUN_LEN + 3) tick(1'b0, 1'b0);

      // Reset mid-transform, then a clean full run.
      for (int it = 0; it < 3; it++) begin
         off = (it == 0) ? 8 : int'($urandom_range(1, RUN_LEN));
         tick(1'b1, 1'b0);
         repeat (off - 1) tick(1'b0, 1'b0);
         reset_mid();
         repeat ($urandom_range(1, 3)) tick(1'b0, 1'b0);
         tick(1'b1, 1'b0);
         repeat (RUN_LEN + 2) tick(1'b0, 1'b0);
      end

`ifdef FFT_SEQ_ABORT_EN
      for (int it = 0; it < 3; it++) begin
         off = (it == 0) ? 7 : int'($urandom_range(1, RUN_LEN - 1));
         s0  = cyc;
         tick(1'b1, 1'b0);
         repeat (off - 1) tick(1'b0, 1'b0);
         tick(1'b0, 1'b1);
         repeat (L + 2) tick(1'b0, 1'b0);
         chk("abort_state", cyc - s0, off + L + 2);
      end
      tick(1'b1, 1'b1);
      repeat (4) tick(1'b0, 1'b0);
`endif

      repeat (2) tick(1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
